// File: rtl/layer_serializer.sv
// layer_serializer
//   Takes a whole layer output vector in one cycle and replays it one element per cycle,
//   in index order. The replayed stream drives the serial input of the next layer.
//   ReLU is optional and is applied once, when the vector is captured.
//   There is no backpressure. A vector that arrives while a frame is still streaming is
//   dropped, and the drop is flagged for one cycle.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   i_valid  in   one-cycle pulse: din holds a complete vector
//   din      in   DATA_WIDTH x NUM_NODES unpacked input vector
//   i_ready  out  an i_valid in this cycle will be accepted
//   dout     out  current serial element (0 when idle)
//   o_valid  out  dout is valid this cycle
//   o_last   out  dout is element NUM_NODES-1 of the frame
//   o_drop   out  one-cycle pulse: an i_valid was rejected in the previous cycle
module layer_serializer #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned NUM_NODES  = 500,
    parameter int unsigned RELU_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] din [NUM_NODES],
    output logic                  i_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  o_valid,
    output logic                  o_last,
    output logic                  o_drop
);

    localparam int unsigned     IdxW    = $clog2(NUM_NODES);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_NODES - 1);
    localparam bit              ReluOn  = (RELU_EN != 0);

    typedef enum logic {
        StIdle,
        StStream
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [IdxW-1:0]       r_idx;
    logic [IdxW-1:0]       w_idx_next;
    logic                  r_drop;
    logic                  w_drop_next;
    logic                  w_at_last;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] r_buf [NUM_NODES];

    // Ready depends only on registered state. It is high in the last element cycle so
    // that a new frame can follow with no idle bubble.
    assign w_at_last = (r_state == StStream) && (r_idx == LastIdx);
    assign i_ready   = (r_state == StIdle) || w_at_last;
    assign w_accept  = i_valid && i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_drop  <= w_drop_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_drop_next  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = StStream;
                    w_idx_next   = '0;
                end
            end
            StStream: begin
                if (w_accept) begin
                    // Reload on the same edge at which the last element retires.
                    w_state_next = StStream;
                    w_idx_next   = '0;
                end else if (w_at_last) begin
                    w_state_next = StIdle;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next   = r_idx + IdxW'(1);
                end
                w_drop_next = i_valid && !i_ready;
            end
            default: begin
                w_state_next = StIdle;
                w_idx_next   = '0;
            end
        endcase
    end

    // The capture buffer is not reset. Its contents matter only while streaming, and
    // streaming always begins with a capture.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < NUM_NODES; k++) begin
                r_buf[k] <= (ReluOn && din[k][DATA_WIDTH-1]) ? '0 : din[k];
            end
        end
    end

    assign o_valid = (r_state == StStream);
    assign o_last  = w_at_last;
    assign o_drop  = r_drop;
    assign dout    = o_valid ? r_buf[r_idx] : '0;

endmodule

// File: tb/tb_layer_serializer.sv
module tb_layer_serializer;

    localparam int DW = 24;
    localparam int NN = 4;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } el_t;

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic [DW-1:0] din [NN];

    // DUT with ReLU
    logic          r_ready, r_valid, r_last, r_drop;
    logic [DW-1:0] r_dout;
    // DUT without ReLU
    logic          n_ready, n_valid, n_last, n_drop;
    logic [DW-1:0] n_dout;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of elements still to be shown (front = current output).
    el_t  q_r[$];
    el_t  q_n[$];
    logic m_drop = 1'b0;

    layer_serializer #(.DATA_WIDTH(DW), .NUM_NODES(NN), .RELU_EN(1)) u_relu (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .din     (din),
        .i_ready (r_ready),
        .dout    (r_dout),
        .o_valid (r_valid),
        .o_last  (r_last),
        .o_drop  (r_drop)
    );

    layer_serializer #(.DATA_WIDTH(DW), .NUM_NODES(NN), .RELU_EN(0)) u_norelu (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .din     (din),
        .i_ready (n_ready),
        .dout    (n_dout),
        .o_valid (n_valid),
        .o_last  (n_last),
        .o_drop  (n_drop)
    );

    wire [DW+3:0] obs_r = {r_valid, r_last, r_drop, r_ready, r_dout};
    wire [DW+3:0] obs_n = {n_valid, n_last, n_drop, n_ready, n_dout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
        return ($signed(x) < 0) ? '0 : x;
    endfunction

    // Expected {o_valid, o_last, o_drop, i_ready, dout} from a model queue.
    function automatic logic [DW+3:0] exp_of(input el_t q[$]);
        logic          v;
        logic          l;
        logic [DW-1:0] d;
        v = (q.size() > 0);
        l = v ? q[0].last : 1'b0;
        d = v ? q[0].d : '0;
        return {v, l, m_drop, (q.size() <= 1), d};
    endfunction

    function automatic void model_reset();
        q_r.delete();
        q_n.delete();
        m_drop = 1'b0;
    endfunction

    // Drive i_valid for one clock edge, advance the model, return at the next negedge.
    task automatic tick(input logic v);
        logic ready;
        i_valid = v;
        @(posedge clk);
        ready = (q_r.size() <= 1);
        if (q_r.size() > 0) begin
            void'(q_r.pop_front());
            void'(q_n.pop_front());
        end
        m_drop = v && !ready;
        if (v && ready) begin
            for (int k = 0; k < NN; k++) begin
                q_r.push_back('{d: relu(din[k]), last: (k == NN - 1)});
                q_n.push_back('{d: din[k], last: (k == NN - 1)});
            end
        end
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic set_vec(input logic [DW-1:0] a, b, c, d);
        din[0] = a;
        din[1] = b;
        din[2] = c;
        din[3] = d;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        i_valid = 1'b0;
        set_vec('0, '0, '0, '0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(1'b0);
            checks++;
            if (obs_r !== {4'b0001, {DW{1'b0}}}) begin
                errors++;
                $display("FAIL reset_idle relu cyc%0d: got %h want %h", c, obs_r,
                         {4'b0001, {DW{1'b0}}});
            end
            checks++;
            if (obs_n !== {4'b0001, {DW{1'b0}}}) begin
                errors++;
                $display("FAIL reset_idle norelu cyc%0d: got %h want %h", c, obs_n,
                         {4'b0001, {DW{1'b0}}});
            end
        end
    endtask

    task automatic test_relu();
        logic [DW-1:0] want_r [NN];
        logic [DW-1:0] want_n [NN];
        want_r = '{24'd5, 24'd0, 24'h7FFFFF, 24'd0};
        want_n = '{24'd5, 24'hFFFFFD, 24'h7FFFFF, 24'h800000};
        set_vec(24'd5, 24'hFFFFFD, 24'h7FFFFF, 24'h800000);
        tick(1'b1);
        for (int k = 0; k < NN; k++) begin
            checks++;
            if (!r_valid || r_dout !== want_r[k] || r_last !== (k == NN - 1)) begin
                errors++;
                $display("FAIL relu_elem%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", k,
                         r_valid, r_dout, r_last, want_r[k], (k == NN - 1));
            end
            checks++;
            if (!n_valid || n_dout !== want_n[k] || n_last !== (k == NN - 1)) begin
                errors++;
                $display("FAIL norelu_elem%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", k,
                         n_valid, n_dout, n_last, want_n[k], (k == NN - 1));
            end
            tick(1'b0);
        end
        checks++;
        if (obs_r !== exp_of(q_r) || obs_n !== exp_of(q_n) || r_valid !== 1'b0) begin
            errors++;
            $display("FAIL relu_idle_after: got %h/%h want %h/%h", obs_r, obs_n,
                     exp_of(q_r), exp_of(q_n));
        end
    endtask

    task automatic test_back_to_back();
        int vcnt = 0;
        set_vec(24'd10, 24'hFFFFF0, 24'd30, 24'd40);
        tick(1'b1);
        for (int c = 0; c < 9; c++) begin
            checks++;
            if (obs_r !== exp_of(q_r) || obs_n !== exp_of(q_n)) begin
                errors++;
                $display("FAIL b2b cyc%0d: got %h/%h want %h/%h", c, obs_r, obs_n,
                         exp_of(q_r), exp_of(q_n));
            end
            if (r_valid) vcnt++;
            if (c == 3) begin
                set_vec(24'd1, 24'd2, 24'd3, 24'd4);
                tick(1'b1);
            end else begin
                tick(1'b0);
            end
        end
        checks++;
        if (vcnt != 8) begin
            errors++;
            $display("FAIL b2b_valid_count: got %0d want 8", vcnt);
        end
    endtask

    task automatic test_overrun();
        int drops = 0;
        int nines = 0;
        set_vec(24'd7, 24'hFFFFFF, 24'd8, 24'd6);
        tick(1'b1);
        tick(1'b0);
        set_vec(24'd9, 24'd9, 24'd9, 24'd9);
        tick(1'b1);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (obs_r !== exp_of(q_r) || obs_n !== exp_of(q_n)) begin
                errors++;
                $display("FAIL overrun cyc%0d: got %h/%h want %h/%h", c, obs_r, obs_n,
                         exp_of(q_r), exp_of(q_n));
            end
            if (r_drop) drops++;
            if (r_valid && r_dout == 24'd9) nines++;
            if (n_valid && n_dout == 24'd9) nines++;
            tick(1'b0);
        end
        checks++;
        if (drops != 1 || nines != 0) begin
            errors++;
            $display("FAIL overrun_summary: got drops=%0d nines=%0d want drops=1 nines=0",
                     drops, nines);
        end
    endtask

    task automatic test_async_reset();
        set_vec(24'd11, 24'd12, 24'd13, 24'd14);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (r_valid !== 1'b0 || n_valid !== 1'b0 || obs_r !== exp_of(q_r)) begin
            errors++;
            $display("FAIL async_reset_now: got %h want %h", obs_r, exp_of(q_r));
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (obs_r !== exp_of(q_r) || obs_n !== exp_of(q_n) || r_ready !== 1'b1) begin
                errors++;
                $display("FAIL async_reset_after cyc%0d: got %h/%h want %h/%h", c, obs_r,
                         obs_n, exp_of(q_r), exp_of(q_n));
            end
            tick(1'b0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NN; k++) din[k] = DW'($urandom);
            tick($urandom_range(0, 2) == 0);
            checks++;
            if (obs_r !== exp_of(q_r) || obs_n !== exp_of(q_n)) begin
                errors++;
                $display("FAIL random cyc%0d: got %h/%h want %h/%h", c, obs_r, obs_n,
                         exp_of(q_r), exp_of(q_n));
            end
        end
    endtask

    initial begin
        test_reset();
        test_relu();
        test_back_to_back();
        repeat (2) tick(1'b0);
        test_overrun();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
